// File: rtl/mem_port_sched.sv
// Shares one external memory port between instruction fetch and data access.
// Data has priority; fetch wins after STARVE_MAX consecutive lost arbitrations.
module mem_port_sched #(
    parameter int width      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [width-1:0] if_addr,
    input  logic             if_flush,
    output logic             if_gnt,
    output logic             if_valid,
    output logic [width-1:0] if_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [1:0]       d_sel,
    input  logic [width-1:0] d_addr,
    input  logic [width-1:0] d_wdata,
    output logic             d_gnt,
    output logic             d_done,
    output logic [width-1:0] d_rdata,
    input  logic             mdelay,
    input  logic [width-1:0] DataIn,
    output logic [width-1:0] AddrOut,
    output logic [width-1:0] DataOut,
    output logic             we,
    output logic             re,
    output logic [1:0]       sel,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC} state_t;

    state_t     state;
    logic [3:0] starve_cnt;
    logic       stale;
    logic       fetch_priority;

    assign fetch_priority = if_req && (starve_cnt == 4'(STARVE_MAX));
    // Grants are gated by reset so nothing is accepted while reset is held.
    assign d_gnt  = rst && (state == IDLE) && d_req && !fetch_priority;
    assign if_gnt = rst && (state == IDLE) && if_req && !d_gnt;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            stale      <= 1'b0;
            if_valid   <= 1'b0;
            if_rdata   <= '0;
            d_done     <= 1'b0;
            d_rdata    <= '0;
            AddrOut    <= '0;
            DataOut    <= '0;
            we         <= 1'b0;
            re         <= 1'b0;
            sel        <= 2'b00;
        end else begin
            if_valid <= 1'b0;
            d_done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (d_gnt) begin
                        state   <= D_ACC;
                        AddrOut <= d_addr;
                        DataOut <= d_we ? d_wdata : '0;
                        sel     <= d_sel;
                        we      <= d_we;
                        re      <= !d_we;
                        if (!if_req) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != 4'(STARVE_MAX)) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end else if (if_gnt) begin
                        state      <= IF_ACC;
                        AddrOut    <= if_addr;
                        DataOut    <= '0;
                        sel        <= 2'b10;
                        we         <= 1'b0;
                        re         <= 1'b1;
                        stale      <= if_flush;
                        starve_cnt <= '0;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                IF_ACC: begin
                    if (if_flush) begin
                        stale <= 1'b1;
                    end
                    if (!mdelay) begin
                        state <= IDLE;
                        re    <= 1'b0;
                        // A flush on the completion cycle also makes the word stale.
                        if (!stale && !if_flush) begin
                            if_rdata <= DataIn;
                            if_valid <= 1'b1;
                        end
                    end
                end
                D_ACC: begin
                    if (!mdelay) begin
                        state  <= IDLE;
                        we     <= 1'b0;
                        re     <= 1'b0;
                        d_done <= 1'b1;
                        if (!we) begin
                            d_rdata <= DataIn;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench for mem_port_sched: a cycle-level transaction model checked on
// every falling edge, plus hand-computed literal expectations per scenario.
module tb_mem_port_sched;

    localparam int W  = 32;
    localparam int SM = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         if_req, if_flush, if_gnt, if_valid;
    logic [W-1:0] if_addr, if_rdata;
    logic         d_req, d_we, d_gnt, d_done;
    logic [1:0]   d_sel;
    logic [W-1:0] d_addr, d_wdata, d_rdata;
    logic         mdelay;
    logic [W-1:0] DataIn, AddrOut, DataOut;
    logic         we, re, busy;
    logic [1:0]   sel;

    always #5 clk = ~clk;

    mem_port_sched #(.width(W), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mdelay(mdelay), .DataIn(DataIn), .AddrOut(AddrOut), .DataOut(DataOut),
        .we(we), .re(re), .sel(sel), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: current transaction kind (0 none, 1 fetch, 2 data) and what the bus shows.
    int           m_acc;
    int           m_cnt;
    bit           m_we, m_stale, m_ifv, m_dd;
    logic [W-1:0] m_addr, m_data, m_ifr, m_dr;
    logic [1:0]   m_sel;

    always @(negedge clk) begin
        bit dwin, fwin;
        if (!rst) begin
            m_acc = 0; m_cnt = 0; m_we = 0; m_stale = 0; m_ifv = 0; m_dd = 0;
            m_addr = '0; m_data = '0; m_ifr = '0; m_dr = '0; m_sel = 2'b00;
        end
        dwin = rst && m_acc == 0 && d_req && !(if_req && m_cnt == SM);
        fwin = rst && m_acc == 0 && !dwin && if_req;
        check("busy", busy, m_acc != 0);
        check("we", we, m_acc == 2 && m_we);
        check("re", re, m_acc == 1 || (m_acc == 2 && !m_we));
        check("AddrOut", AddrOut, m_addr);
        check("DataOut", DataOut, m_data);
        check("sel", sel, m_sel);
        check("d_gnt", d_gnt, dwin);
        check("if_gnt", if_gnt, fwin);
        check("if_valid", if_valid, m_ifv);
        check("d_done", d_done, m_dd);
        check("if_rdata", if_rdata, m_ifr);
        check("d_rdata", d_rdata, m_dr);
        if (rst) begin
            m_ifv = 0;
            m_dd  = 0;
            if (m_acc == 0) begin
                if (dwin) begin
                    m_acc = 2; m_we = d_we; m_addr = d_addr; m_sel = d_sel;
                    m_data = d_we ? d_wdata : '0;
                end else if (fwin) begin
                    m_acc = 1; m_addr = if_addr; m_data = '0; m_sel = 2'b10;
                    m_stale = if_flush;
                end
                m_cnt = (dwin && if_req) ? ((m_cnt < SM) ? m_cnt + 1 : SM) : 0;
            end else begin
                if (m_acc == 1 && if_flush) m_stale = 1;
                if (!mdelay) begin
                    if (m_acc == 1 && !m_stale) begin
                        m_ifv = 1;
                        m_ifr = DataIn;
                    end
                    if (m_acc == 2) begin
                        m_dd = 1;
                        if (!m_we) m_dr = DataIn;
                    end
                    m_acc = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int seq[16];
        int n;
        int exp_seq[10];
        exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        // Reset held with both requests pending.
        rst = 0; if_req = 1; d_req = 1; if_flush = 0; if_addr = '0;
        d_we = 0; d_sel = 2'b10; d_addr = 32'h40; d_wdata = '0;
        mdelay = 0; DataIn = 32'h1111_2222;
        repeat (3) tick();
        check("rst_d_gnt", d_gnt, 0);
        check("rst_if_gnt", if_gnt, 0);
        check("rst_re", re, 0);
        rst = 1;
        #1;
        check("rel_d_gnt", d_gnt, 1);
        check("rel_if_gnt", if_gnt, 0);
        tick();
        d_req = 0; if_req = 0;
        check("rel_re", re, 1);
        check("rel_addr", AddrOut, 32'h40);
        tick();
        check("rel_d_done", d_done, 1);
        check("rel_d_rdata", d_rdata, 32'h1111_2222);

        // Single fetch, no wait states.
        if_req = 1; if_addr = 32'h100; DataIn = 32'h0050_0093;
        #1;
        check("f_gnt", if_gnt, 1);
        tick();
        if_req = 0;
        check("f_re", re, 1);
        check("f_addr", AddrOut, 32'h100);
        tick();
        check("f_valid", if_valid, 1);
        check("f_rdata", if_rdata, 32'h0050_0093);

        // Store with three wait cycles.
        d_req = 1; d_we = 1; d_sel = 2'b10; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
        mdelay = 1;
        #1;
        check("s_gnt", d_gnt, 1);
        tick();
        d_req = 0;
        for (int i = 0; i < 4; i++) begin
            mdelay = (i < 3);
            check("s_we", we, 1);
            check("s_addr", AddrOut, 32'h2000);
            check("s_data", DataOut, 32'hDEAD_BEEF);
            check("s_done_early", d_done, 0);
            tick();
        end
        check("s_done", d_done, 1);
        check("s_rdata_kept", d_rdata, 32'h1111_2222);
        check("s_we_off", we, 0);

        // Contention: four data grants then one fetch grant, repeating.
        d_we = 0; d_addr = 32'h400; if_addr = 32'h500; DataIn = 32'hA5A5_0001;
        d_req = 1; if_req = 1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (d_gnt) begin
                if (n < 16) seq[n] = 0;
                n++;
            end else if (if_gnt) begin
                if (n < 16) seq[n] = 1;
                n++;
            end
            tick();
        end
        d_req = 0; if_req = 0;
        check("c_count", n, 10);
        for (int k = 0; k < 10; k++) check($sformatf("c_seq%0d", k), seq[k], exp_seq[k]);
        tick();
        tick();

        // Flush during a stalled fetch.
        if_req = 1; if_addr = 32'h200; mdelay = 1; DataIn = 32'hBAD0_BAD0;
        #1;
        check("fl_gnt", if_gnt, 1);
        tick();
        if_req = 0;
        tick();
        if_flush = 1;
        tick();
        if_flush = 0; mdelay = 0;
        check("fl_re", re, 1);
        check("fl_addr", AddrOut, 32'h200);
        tick();
        check("fl_valid", if_valid, 0);
        check("fl_rdata", if_rdata, 32'hA5A5_0001);
        if_req = 1; if_addr = 32'h204; DataIn = 32'h1234_5678;
        #1;
        check("fl2_gnt", if_gnt, 1);
        tick();
        if_req = 0;
        tick();
        check("fl2_valid", if_valid, 1);
        check("fl2_rdata", if_rdata, 32'h1234_5678);

        // Flush in the grant cycle makes the fetch stale.
        if_req = 1; if_flush = 1; if_addr = 32'h300; DataIn = 32'hFFFF_0000;
        #1;
        check("fg_gnt", if_gnt, 1);
        tick();
        if_req = 0; if_flush = 0;
        tick();
        check("fg_valid", if_valid, 0);
        check("fg_rdata", if_rdata, 32'h1234_5678);

        // Flush in IDLE with no request is ignored.
        if_flush = 1;
        tick();
        if_flush = 0; if_req = 1; if_addr = 32'h304; DataIn = 32'h0BAD_F00D;
        tick();
        if_req = 0;
        tick();
        check("fi_valid", if_valid, 1);
        check("fi_rdata", if_rdata, 32'h0BAD_F00D);

        // Asynchronous reset in the middle of a store.
        d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'h55; mdelay = 1;
        #1;
        check("ar_gnt", d_gnt, 1);
        tick();
        d_req = 0;
        check("ar_we_on", we, 1);
        #2;
        rst = 0;
        #1;
        check("ar_we", we, 0);
        check("ar_re", re, 0);
        check("ar_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1; mdelay = 0;
        tick();
        check("ar_done", d_done, 0);
        check("ar_idle", busy, 0);
        tick();
        check("ar_done2", d_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
